// File: rtl/fir_pkg.sv
// fir_pkg: definitions shared by the FIR coefficient loader and its bench.
//   state_t        - loader FSM states
//   FP16 / FP16i   - field widths and bit positions of both number formats
//   fp16_to_fp16i  - IEEE FP16 -> FP16i with the hidden bit made explicit
package fir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    SETUP,
    STROBE,
    HOLD,
    DONE,
    ERR
  } state_t;

  // IEEE FP16: {sign[15], exp[14:10], mantissa[9:0]}
  localparam int unsigned FP16_W        = 16;
  localparam int unsigned FP16_SIGN_BIT = 15;
  localparam int unsigned FP16_EXP_LSB  = 10;
  localparam int unsigned EXP_W         = 5;
  localparam int unsigned MAN_W         = 10;

  // FP16i: {sign[16], exp[15:11], raw mantissa[10:0]} with explicit hidden bit at [10]
  localparam int unsigned FP16I_W        = 17;
  localparam int unsigned FP16I_SIGN_BIT = 16;
  localparam int unsigned FP16I_EXP_LSB  = 11;
  localparam int unsigned FP16I_HID_BIT  = 10;

  // Hidden bit is 0 only for zero/subnormal (biased exponent 0).
  function automatic logic [FP16I_W-1:0] fp16_to_fp16i(input logic [FP16_W-1:0] h);
    logic [FP16I_W-1:0] r;
    logic [EXP_W-1:0]   e;
    e = h[FP16_EXP_LSB +: EXP_W];
    r = '0;
    r[FP16I_SIGN_BIT]              = h[FP16_SIGN_BIT];
    r[FP16I_EXP_LSB +: EXP_W]      = e;
    r[FP16I_HID_BIT]               = (e != '0);
    r[MAN_W-1:0]                   = h[MAN_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/fir_strobe_gen.sv
// fir_strobe_gen: setup / high / hold phase timer for one coefficient write.
//   clk_fast, rst_n - clock, asynchronous active-low reset
//   go              - one-cycle pulse: start a setup/strobe/hold cycle
//   abort           - drop cload and return to idle on this edge
//   cload           - registered write strobe, high for HIGH_CYC cycles
//   setup_end       - last cycle of the setup phase
//   high_end        - last cycle of the strobe-high phase
//   phase_done      - last cycle of the hold phase
module fir_strobe_gen
  import fir_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned HIGH_CYC  = 1,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic clk_fast,
  input  logic rst_n,
  input  logic go,
  input  logic abort,
  output logic cload,
  output logic setup_end,
  output logic high_end,
  output logic phase_done
);

  localparam int unsigned MAX_SH  = (SETUP_CYC > HIGH_CYC) ? SETUP_CYC : HIGH_CYC;
  localparam int unsigned MAX_CYC = (MAX_SH > HOLD_CYC) ? MAX_SH : HOLD_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  if (SETUP_CYC < 1 || HIGH_CYC < 1 || HOLD_CYC < 1) begin : g_bad_phase
    $error("fir_strobe_gen: every phase length must be at least one cycle");
  end

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_HIGH,
    PH_HOLD
  } phase_t;

  phase_t             phase;
  logic [CNT_W-1:0]   cnt;

  always_comb begin
    setup_end  = (phase == PH_SETUP) && (cnt == CNT_W'(SETUP_CYC - 1));
    high_end   = (phase == PH_HIGH)  && (cnt == CNT_W'(HIGH_CYC - 1));
    phase_done = (phase == PH_HOLD)  && (cnt == CNT_W'(HOLD_CYC - 1));
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      phase <= PH_IDLE;
      cnt   <= '0;
      cload <= 1'b0;
    end else if (abort) begin
      phase <= PH_IDLE;
      cnt   <= '0;
      cload <= 1'b0;
    end else if (go) begin
      phase <= PH_SETUP;
      cnt   <= '0;
    end else begin
      case (phase)
        PH_SETUP: begin
          if (setup_end) begin
            phase <= PH_HIGH;
            cnt   <= '0;
            cload <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PH_HIGH: begin
          if (high_end) begin
            phase <= PH_HOLD;
            cnt   <= '0;
            cload <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PH_HOLD: begin
          if (phase_done) begin
            phase <= PH_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fir_coef_loader.sv
// fir_coef_loader: writes NCOEF host coefficients into the FIR coefficient
// memory through the cin/caddr/cload port, within the post-reset load window.
//   clk_fast, rst_n        - clock, asynchronous active-low reset
//   start                  - pulse; begins a load sequence when not busy
//   host_valid/host_ready  - coefficient stream handshake, one beat per coefficient
//   host_data              - coefficient (FP16i, or FP16 in [15:0] with conversion)
//   caddr, cin, cload      - FIR coefficient write port (rising cload writes)
//   busy                   - sequence in progress
//   done, err              - sticky completion / window-expiry flags, cleared by start
// Build option: define FP16_CONVERT_EN to convert IEEE FP16 host data to FP16i
// on capture; otherwise host_data is passed through unchanged.
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int unsigned NCOEF       = 64,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned DATA_W      = 17,
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned HIGH_CYC    = 1,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned LOAD_WINDOW = 512
) (
  input  logic              clk_fast,
  input  logic              rst_n,
  input  logic              start,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [DATA_W-1:0] host_data,
  output logic [ADDR_W-1:0] caddr,
  output logic [DATA_W-1:0] cin,
  output logic              cload,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned WIN_W = $clog2(LOAD_WINDOW + 1);

  if (NCOEF < 1 || NCOEF > (1 << ADDR_W)) begin : g_bad_ncoef
    $error("fir_coef_loader: NCOEF must be in 1..2**ADDR_W");
  end
  if (LOAD_WINDOW < 2) begin : g_bad_window
    $error("fir_coef_loader: LOAD_WINDOW must be at least 2");
  end

  state_t             state;
  logic [ADDR_W-1:0]  index;
  logic [WIN_W-1:0]   win_cnt;
  logic [DATA_W-1:0]  cin_cap;
  logic               accept;
  logic               last;
  logic               finishing;
  logic               expire;
  logic               setup_end;
  logic               high_end;
  logic               phase_done;

`ifdef FP16_CONVERT_EN
  assign cin_cap = DATA_W'(fp16_to_fp16i(host_data[FP16_W-1:0]));
`else
  assign cin_cap = host_data;
`endif

  // Completion outranks window expiry when both land on the same edge.
  always_comb begin
    accept    = (state == WAIT) && host_valid && host_ready;
    last      = (index == ADDR_W'(NCOEF - 1));
    finishing = ((state == HOLD) && phase_done && last) || (state == DONE);
    expire    = busy && (win_cnt >= WIN_W'(LOAD_WINDOW - 1)) && !finishing;
  end

  fir_strobe_gen #(
    .SETUP_CYC (SETUP_CYC),
    .HIGH_CYC  (HIGH_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) u_strobe (
    .clk_fast   (clk_fast),
    .rst_n      (rst_n),
    .go         (accept),
    .abort      (expire),
    .cload      (cload),
    .setup_end  (setup_end),
    .high_end   (high_end),
    .phase_done (phase_done)
  );

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      index      <= '0;
      win_cnt    <= '0;
      host_ready <= 1'b0;
      caddr      <= '0;
      cin        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (busy && (win_cnt != WIN_W'(LOAD_WINDOW)))
        win_cnt <= win_cnt + WIN_W'(1);

      if (expire) begin
        state      <= ERR;
        host_ready <= 1'b0;
        busy       <= 1'b0;
        err        <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state      <= WAIT;
              index      <= '0;
              win_cnt    <= '0;
              host_ready <= 1'b1;
              busy       <= 1'b1;
              done       <= 1'b0;
              err        <= 1'b0;
            end
          end
          WAIT: begin
            if (accept) begin
              cin        <= cin_cap;
              caddr      <= index;
              host_ready <= 1'b0;
              state      <= SETUP;
            end
          end
          SETUP: begin
            if (setup_end) state <= STROBE;
          end
          STROBE: begin
            if (high_end) state <= HOLD;
          end
          HOLD: begin
            if (phase_done) begin
              if (last) begin
                state <= DONE;
              end else begin
                index      <= index + ADDR_W'(1);
                host_ready <= 1'b1;
                state      <= WAIT;
              end
            end
          end
          DONE: begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
          ERR: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// tb_fir_coef_loader: table-driven load sequences with a scoreboard of
// expected (caddr, cin) pairs popped on every cload rising edge, plus
// hand-written window-expiry and mid-strobe reset sequences.
module tb_fir_coef_loader;
  import fir_pkg::*;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 17;
  localparam int unsigned NCOEF  = 64;

  logic clk_fast = 1'b0;
  logic rst_n    = 1'b0;
  always #5 clk_fast = ~clk_fast;

  logic              start, host_valid, host_ready, cload, busy, done, err;
  logic [DATA_W-1:0] host_data, cin;
  logic [ADDR_W-1:0] caddr;

  logic              start_w, host_valid_w, host_ready_w, cload_w, busy_w, done_w, err_w;
  logic [DATA_W-1:0] host_data_w, cin_w;
  logic [ADDR_W-1:0] caddr_w;

  fir_coef_loader dut (
    .clk_fast   (clk_fast),
    .rst_n      (rst_n),
    .start      (start),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_data  (host_data),
    .caddr      (caddr),
    .cin        (cin),
    .cload      (cload),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  fir_coef_loader #(.LOAD_WINDOW(100)) dut_win (
    .clk_fast   (clk_fast),
    .rst_n      (rst_n),
    .start      (start_w),
    .host_valid (host_valid_w),
    .host_ready (host_ready_w),
    .host_data  (host_data_w),
    .caddr      (caddr_w),
    .cin        (cin_w),
    .cload      (cload_w),
    .busy       (busy_w),
    .done       (done_w),
    .err        (err_w)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk_fast) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] model(input logic [DATA_W-1:0] d);
`ifdef FP16_CONVERT_EN
    return fp16_to_fp16i(d[15:0]);
`else
    return d;
`endif
  endfunction

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t sb[$];

  // Strobe monitor: pops the scoreboard on each cload rise and checks setup,
  // strobe width and hold stability of caddr/cin.
  int                strobes = 0;
  logic              cload_q = 1'b0;
  int                hi_len  = 0;
  logic [ADDR_W-1:0] caddr_q = '0;
  logic [DATA_W-1:0] cin_q   = '0;
  beat_t             cur     = '0;

  always @(negedge clk_fast) begin : mon
    beat_t b;
    if (!rst_n) begin
      cload_q <= 1'b0;
      hi_len  <= 0;
    end else begin
      if (cload && !cload_q) begin
        strobes <= strobes + 1;
        hi_len  <= 1;
        check("setup_caddr_stable", 32'(caddr), 32'(caddr_q));
        check("setup_cin_stable", 32'(cin), 32'(cin_q));
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          b = sb.pop_front();
          cur <= b;
          check("caddr", 32'(caddr), 32'(b.addr));
          check("cin", 32'(cin), 32'(b.data));
        end
      end else if (cload) begin
        hi_len <= hi_len + 1;
      end else if (cload_q) begin
        check("cload_width", 32'(hi_len), 32'd1);
        check("hold_caddr", 32'(caddr), 32'(cur.addr));
        check("hold_cin", 32'(cin), 32'(cur.data));
      end
      cload_q <= cload;
    end
    caddr_q <= caddr;
    cin_q   <= cin;
  end

  typedef struct {
    int stall_idx;
    int stall_len;
    int restart_idx;
    int exp_cycles;
  } row_t;

  task automatic run_seq(input row_t r, input string tag);
    int    beat = 0;
    int    stall = 0;
    int    t0, s0, elapsed;
    bit    restarted = 1'b0;
    beat_t b;
    @(negedge clk_fast);
    start      = 1'b1;
    host_valid = 1'b0;
    @(negedge clk_fast);
    start = 1'b0;
    t0    = cyc;
    s0    = strobes;
    check({tag, "_busy_on_start"}, 32'(busy), 32'd1);
    check({tag, "_done_cleared"}, 32'(done), 32'd0);
    check({tag, "_err_clear"}, 32'(err), 32'd0);
    for (int i = 0; i < 1000; i++) begin
      if (done || err) break;
      start = 1'b0;
      if (r.restart_idx >= 0 && !restarted && beat == r.restart_idx) begin
        start     = 1'b1;
        restarted = 1'b1;
      end
      if (beat == r.stall_idx && host_ready && stall < r.stall_len) begin
        host_valid = 1'b0;
        stall++;
        check({tag, "_stall_no_strobe"}, 32'(cload), 32'd0);
      end else begin
        host_valid = 1'b1;
        host_data  = DATA_W'(beat * 3);
      end
      if (host_valid && host_ready) begin
        b.addr = ADDR_W'(beat);
        b.data = model(host_data);
        sb.push_back(b);
        beat++;
      end
      @(negedge clk_fast);
    end
    elapsed    = cyc - t0;
    host_valid = 1'b0;
    start      = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_cycles"}, 32'(elapsed), 32'(r.exp_cycles));
    check({tag, "_strobes"}, 32'(strobes - s0), 32'(NCOEF));
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk_fast);
    check({tag, "_done_sticky"}, 32'(done), 32'd1);
  endtask

  row_t rows[3];
  int   t0, elapsed, n_str, beat;
  bit   prev, seen, found;
  beat_t bb;

  initial begin
    start        = 1'b0;
    host_valid   = 1'b0;
    host_data    = '0;
    start_w      = 1'b0;
    host_valid_w = 1'b0;
    host_data_w  = '0;

    rows[0] = '{stall_idx: -1, stall_len: 0,  restart_idx: -1, exp_cycles: 257};
    rows[1] = '{stall_idx: 5,  stall_len: 10, restart_idx: -1, exp_cycles: 267};
    rows[2] = '{stall_idx: -1, stall_len: 0,  restart_idx: 10, exp_cycles: 257};

    repeat (3) @(negedge clk_fast);
    check("rst_host_ready", 32'(host_ready), 32'd0);
    check("rst_caddr", 32'(caddr), 32'd0);
    check("rst_cin", 32'(cin), 32'd0);
    check("rst_cload", 32'(cload), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    check("fp16i_one", 32'(fp16_to_fp16i(16'h3C00)), 32'h07C00);
    check("fp16i_subnormal", 32'(fp16_to_fp16i(16'h8001)), 32'h10001);

    for (int i = 0; i < 3; i++) run_seq(rows[i], $sformatf("row%0d", i));

    // Window expiry with LOAD_WINDOW=100 and a host that is always valid.
    @(negedge clk_fast);
    start_w      = 1'b1;
    host_valid_w = 1'b1;
    host_data_w  = 17'h00155;
    @(negedge clk_fast);
    start_w = 1'b0;
    t0      = cyc;
    n_str   = 0;
    prev    = 1'b0;
    seen    = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (cload_w && !prev) n_str++;
      prev = cload_w;
      if (err_w) begin
        elapsed = cyc - t0;
        seen    = 1'b1;
        check("win_err_cycle", 32'(elapsed), 32'd100);
        check("win_cload", 32'(cload_w), 32'd0);
        check("win_busy", 32'(busy_w), 32'd0);
        check("win_done", 32'(done_w), 32'd0);
        check("win_host_ready", 32'(host_ready_w), 32'd0);
        check("win_strobes", 32'(n_str), 32'd25);
        break;
      end
      @(negedge clk_fast);
    end
    check("win_err_seen", 32'(seen), 32'd1);
    repeat (2) @(negedge clk_fast);
    start_w = 1'b1;
    @(negedge clk_fast);
    start_w = 1'b0;
    check("win_restart_err_cleared", 32'(err_w), 32'd0);
    check("win_restart_busy", 32'(busy_w), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cload_w) begin
        seen = 1'b1;
        check("win_restart_caddr", 32'(caddr_w), 32'd0);
        check("win_restart_cin", 32'(cin_w), 32'(model(17'h00155)));
        break;
      end
      @(negedge clk_fast);
    end
    check("win_restart_strobe_seen", 32'(seen), 32'd1);
    host_valid_w = 1'b0;

    // Reset asserted while coefficient 20 is strobing.
    @(negedge clk_fast);
    start = 1'b1;
    @(negedge clk_fast);
    start = 1'b0;
    beat  = 0;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (cload && caddr == ADDR_W'(20)) begin
        found = 1'b1;
        break;
      end
      host_valid = 1'b1;
      host_data  = DATA_W'(beat * 3);
      if (host_ready) begin
        bb.addr = ADDR_W'(beat);
        bb.data = model(host_data);
        sb.push_back(bb);
        beat++;
      end
      @(negedge clk_fast);
    end
    check("rst_mid_found_strobe20", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_cload", 32'(cload), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_host_ready", 32'(host_ready), 32'd0);
    check("rst_mid_caddr", 32'(caddr), 32'd0);
    check("rst_mid_cin", 32'(cin), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_err", 32'(err), 32'd0);
    host_valid = 1'b0;
    @(negedge clk_fast);
    #2 rst_n = 1'b1;
    sb.delete();
    run_seq(rows[0], "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
